// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and constants for the DCache posted-write buffer.
// Widths are fixed here so the entry struct and the tag slice stay consistent.
package wb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 256;
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int TAG_W  = ADDR_W - OFF_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HIT  = 2'd1,
    R_AR   = 2'd2,
    R_DATA = 2'd3
  } rd_state_e;

  function automatic tag_t line_tag(input addr_t a);
    return a[ADDR_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/dcache_write_buffer_fifo.sv
// DEPTH-entry line FIFO for the write buffer. Entries are also presented in
// age order (index 0 = head) with valid bits for the parallel tag compare.
module wb_entry_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count_next,
  output wb_entry_t        head_next,
  output wb_entry_t        entries [DEPTH],
  output logic             valid [DEPTH]
);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] head_inc_s;

  assign full       = (count_r == CNT_W'(DEPTH));
  assign empty      = (count_r == {CNT_W{1'b0}});
  assign head_inc_s = head_r + PTR_W'(1);

  // Occupancy update and the entry that will sit at the head next cycle.
  always_comb begin
    count_next = count_r;
    head_next  = mem_r[head_r];
    case ({push, pop})
      2'b10:   count_next = count_r + CNT_W'(1);
      2'b01:   count_next = count_r - CNT_W'(1);
      default: count_next = count_r;
    endcase
    // A push into a buffer that is (or is becoming) empty lands directly at the head.
    if (push && (count_r == CNT_W'(pop))) begin
      head_next = push_entry;
    end else if (pop) begin
      head_next = mem_r[head_inc_s];
    end else begin
      head_next = mem_r[head_r];
    end
  end

  // Age-ordered view of the storage for the read-hit compare.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem_r[head_r + PTR_W'(k)];
      valid[k]   = (CNT_W'(k) < count_r);
    end
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[tail_r] <= push_entry;
        tail_r        <= tail_r + PTR_W'(1);
      end
      if (pop) begin
        head_r <= head_inc_s;
      end
      count_r <= count_next;
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the DCache AXI4-Lite port and interconnect M1:
// evictions are queued and drained in the background, reads may hit the queue.
module dcache_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push_s, pop_s, full_s, empty_s;
  logic [CNT_W-1:0] count_next_s;
  wb_entry_t        push_entry_s, head_next_s;
  wb_entry_t        entries_s [DEPTH];
  logic             valid_s [DEPTH];

  logic             aw_hs_s, w_hs_s, aw_done_next_s, w_done_next_s;
  logic             aw_done_r, w_done_r, m_awvalid_r, m_wvalid_r;
  addr_t            m_awaddr_r, m_araddr_r, araddr_next_s;
  data_t            m_wdata_r, rdata_r, rdata_next_s, hit_data_s;
  logic             hit_s, ar_accept_s;
  rd_state_e        state_r, state_next_s;

  assign push_s       = !full_s && s_awvalid && s_wvalid;
  assign s_awready    = push_s;
  assign s_wready     = push_s;
  assign push_entry_s = '{addr: s_awaddr, data: s_wdata};

  wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .full       (full_s),
    .empty      (empty_s),
    .count_next (count_next_s),
    .head_next  (head_next_s),
    .entries    (entries_s),
    .valid      (valid_s)
  );

  // Drain handshake tracking: AW and W may complete in different cycles.
  always_comb begin
    aw_hs_s = m_awvalid_r && m_awready;
    w_hs_s  = m_wvalid_r && m_wready;
    pop_s   = !empty_s && (aw_done_r || aw_hs_s) && (w_done_r || w_hs_s);
    if (pop_s) begin
      aw_done_next_s = 1'b0;
      w_done_next_s  = 1'b0;
    end else begin
      aw_done_next_s = aw_done_r || aw_hs_s;
      w_done_next_s  = w_done_r || w_hs_s;
    end
  end

  // Registered downstream write channel, preloaded with next cycle's head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      m_awvalid_r <= 1'b0;
      m_wvalid_r  <= 1'b0;
      m_awaddr_r  <= '0;
      m_wdata_r   <= '0;
    end else begin
      aw_done_r   <= aw_done_next_s;
      w_done_r    <= w_done_next_s;
      m_awvalid_r <= (count_next_s != {CNT_W{1'b0}}) && !aw_done_next_s;
      m_wvalid_r  <= (count_next_s != {CNT_W{1'b0}}) && !w_done_next_s;
      if (count_next_s != {CNT_W{1'b0}}) begin
        m_awaddr_r <= head_next_s.addr;
        m_wdata_r  <= head_next_s.data;
      end
    end
  end

  assign m_awvalid = m_awvalid_r;
  assign m_wvalid  = m_wvalid_r;
  assign m_awaddr  = m_awaddr_r;
  assign m_wdata   = m_wdata_r;
  assign m_araddr  = m_araddr_r;

  // Newest matching entry wins: later (younger) matches overwrite earlier ones.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_s[k] && (line_tag(entries_s[k].addr) == line_tag(s_araddr))) begin
        hit_s      = 1'b1;
        hit_data_s = entries_s[k].data;
      end
    end
  end

  // Read FSM next state and read-side outputs.
  always_comb begin
    state_next_s  = state_r;
    rdata_next_s  = rdata_r;
    araddr_next_s = m_araddr_r;
    s_arready     = 1'b0;
    s_rvalid      = 1'b0;
    s_rdata       = '0;
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    ar_accept_s   = 1'b0;
    case (state_r)
      R_IDLE: begin
        s_arready   = !push_s;
        ar_accept_s = s_arvalid && !push_s;
        if (ar_accept_s && hit_s) begin
          state_next_s = R_HIT;
          rdata_next_s = hit_data_s;
        end else if (ar_accept_s) begin
          state_next_s  = R_AR;
          araddr_next_s = s_araddr;
        end else begin
          state_next_s = R_IDLE;
        end
      end
      R_HIT: begin
        s_rvalid = 1'b1;
        s_rdata  = rdata_r;
        if (s_rready) begin
          state_next_s = R_IDLE;
        end else begin
          state_next_s = R_HIT;
        end
      end
      R_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_next_s = R_DATA;
        end else begin
          state_next_s = R_AR;
        end
      end
      R_DATA: begin
        s_rvalid = m_rvalid;
        s_rdata  = m_rdata;
        m_rready = s_rready;
        if (m_rvalid && s_rready) begin
          state_next_s = R_IDLE;
        end else begin
          state_next_s = R_DATA;
        end
      end
      default: state_next_s = R_IDLE;
    endcase
  end

  // Read FSM state and latched read address / hit data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= R_IDLE;
      rdata_r    <= '0;
      m_araddr_r <= '0;
    end else begin
      state_r    <= state_next_s;
      rdata_r    <= rdata_next_s;
      m_araddr_r <= araddr_next_s;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed self-checking bench for dcache_write_buffer.
module tb_dcache_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic         s_awvalid, s_awready, s_wvalid, s_wready;
  logic [255:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;
  logic         m_awvalid, m_awready, m_wvalid, m_wready;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;

  int n_vec  = 0;
  int n_miss = 0;

  logic [255:0] d_d = {8{32'hD00D_0001}};
  logic [255:0] d_e = {8{32'hE0E0_0002}};
  logic [255:0] d_a = {8{32'hAAAA_0003}};
  logic [255:0] d_b = {8{32'hBBBB_0004}};
  logic [255:0] d_x = {8{32'h1234_5678}};

  dcache_write_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [11:0] a, input logic [255:0] d);
    s_awaddr  = a;
    s_wdata   = d;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
  endtask

  task automatic idle_write();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_rdata = '0; m_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_m_awvalid", m_awvalid, 1'b0);
    check("rst_m_wvalid", m_wvalid, 1'b0);
    check("rst_s_rvalid", s_rvalid, 1'b0);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_rready", m_rready, 1'b0);
    check("rst_s_rdata", s_rdata, 256'd0);
    check("rst_m_awaddr", m_awaddr, 12'h000);
    check("rst_m_wdata", m_wdata, 256'd0);
    check("rst_m_araddr", m_araddr, 12'h000);
    check("rst_s_arready", s_arready, 1'b1);

    // Single write with downstream ready.
    m_awready = 1'b1; m_wready = 1'b1;
    drive_write(12'h040, d_d);
    #1;
    check("wr1_s_awready", s_awready, 1'b1);
    check("wr1_s_wready", s_wready, 1'b1);
    step();
    idle_write();
    #1;
    check("wr1_m_awvalid", m_awvalid, 1'b1);
    check("wr1_m_wvalid", m_wvalid, 1'b1);
    check("wr1_m_awaddr", m_awaddr, 12'h040);
    check("wr1_m_wdata", m_wdata, d_d);
    step();
    check("wr1_drained_awvalid", m_awvalid, 1'b0);
    check("wr1_count", dut.u_fifo.count_r, 2'd0);

    // Full stall then release.
    m_awready = 1'b0; m_wready = 1'b0;
    drive_write(12'h000, d_a);
    step();
    drive_write(12'h020, d_b);
    step();
    drive_write(12'h040, d_d);
    #1;
    check("full_s_awready", s_awready, 1'b0);
    check("full_head_addr", m_awaddr, 12'h000);
    step();
    m_awready = 1'b1; m_wready = 1'b1;
    #1;
    check("full_pop_cycle_awready", s_awready, 1'b0);
    step();
    check("full_accept_awready", s_awready, 1'b1);
    check("b2b_m_awvalid", m_awvalid, 1'b1);
    check("b2b_m_awaddr", m_awaddr, 12'h020);
    step();
    idle_write();
    #1;
    check("full_third_addr", m_awaddr, 12'h040);
    check("full_third_wdata", m_wdata, d_d);
    check("full_third_count", dut.u_fifo.count_r, 2'd1);
    step();
    check("full_empty_awvalid", m_awvalid, 1'b0);

    // Split handshake: AW at N+1, W at N+3.
    m_awready = 1'b0; m_wready = 1'b0;
    drive_write(12'h060, d_e);
    step();
    idle_write();
    m_awready = 1'b1;
    #1;
    check("split_n1_awvalid", m_awvalid, 1'b1);
    check("split_n1_wvalid", m_wvalid, 1'b1);
    step();
    m_awready = 1'b0;
    #1;
    check("split_n2_awvalid", m_awvalid, 1'b0);
    check("split_n2_wvalid", m_wvalid, 1'b1);
    check("split_n2_count", dut.u_fifo.count_r, 2'd1);
    step();
    m_wready = 1'b1;
    #1;
    check("split_n3_wvalid", m_wvalid, 1'b1);
    check("split_n3_count", dut.u_fifo.count_r, 2'd1);
    step();
    m_wready = 1'b0;
    check("split_n4_wvalid", m_wvalid, 1'b0);
    check("split_n4_count", dut.u_fifo.count_r, 2'd0);

    // Read hit, newest entry wins; a concurrent push blocks the read for a cycle.
    drive_write(12'h080, d_a);
    step();
    drive_write(12'h080, d_b);
    s_araddr  = 12'h09C;
    s_arvalid = 1'b1;
    s_rready  = 1'b1;
    #1;
    check("hit_push_blocks_ar", s_arready, 1'b0);
    step();
    idle_write();
    #1;
    check("hit_ar_accept", s_arready, 1'b1);
    check("hit_n_m_arvalid", m_arvalid, 1'b0);
    step();
    s_arvalid = 1'b0;
    #1;
    check("hit_s_rvalid", s_rvalid, 1'b1);
    check("hit_s_rdata", s_rdata, d_b);
    check("hit_m_arvalid", m_arvalid, 1'b0);
    step();
    check("hit_done_rvalid", s_rvalid, 1'b0);
    check("hit_done_m_arvalid", m_arvalid, 1'b0);
    m_awready = 1'b1; m_wready = 1'b1;
    repeat (4) step();
    check("hit_drained_count", dut.u_fifo.count_r, 2'd0);

    // Read miss through to the interconnect.
    s_araddr  = 12'h100;
    s_arvalid = 1'b1;
    #1;
    check("miss_ar_accept", s_arready, 1'b1);
    step();
    s_arvalid = 1'b0;
    #1;
    check("miss_m_arvalid", m_arvalid, 1'b1);
    check("miss_m_araddr", m_araddr, 12'h100);
    check("miss_no_rvalid", s_rvalid, 1'b0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    #1;
    check("miss_ar_dropped", m_arvalid, 1'b0);
    check("miss_wait_rvalid", s_rvalid, 1'b0);
    m_rdata  = d_x;
    m_rvalid = 1'b1;
    #1;
    check("miss_s_rvalid", s_rvalid, 1'b1);
    check("miss_s_rdata", s_rdata, d_x);
    check("miss_m_rready", m_rready, 1'b1);
    step();
    m_rvalid = 1'b0;
    #1;
    check("miss_done_rvalid", s_rvalid, 1'b0);
    check("miss_done_arready", s_arready, 1'b1);

    // Reset while draining with two entries buffered.
    m_awready = 1'b0; m_wready = 1'b0;
    drive_write(12'h0C0, d_a);
    step();
    drive_write(12'h0E0, d_b);
    step();
    idle_write();
    #1;
    check("rstmid_pre_awvalid", m_awvalid, 1'b1);
    check("rstmid_pre_count", dut.u_fifo.count_r, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("rstmid_awvalid", m_awvalid, 1'b0);
    check("rstmid_wvalid", m_wvalid, 1'b0);
    check("rstmid_awaddr", m_awaddr, 12'h000);
    check("rstmid_count", dut.u_fifo.count_r, 2'd0);
    step();
    rst = 1'b0;
    step();
    check("rstmid_post_arready", s_arready, 1'b1);
    check("rstmid_post_count", dut.u_fifo.count_r, 2'd0);
    check("rstmid_post_awvalid", m_awvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
